// File: rtl/memory_responder_if.sv
// CPU-to-memory bus between the instruction control FSM (master) and the memory responder (slave).
interface memory_responder_if;
  logic        mem_read;
  logic        mem_write;
  logic [15:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic [7:0]  data_bus;
  logic        rd_valid;
  logic        ready;

  modport master (
    output mem_read, mem_write, mem_addr, mem_wdata,
    input  data_bus, rd_valid, ready
  );

  modport slave (
    input  mem_read, mem_write, mem_addr, mem_wdata,
    output data_bus, rd_valid, ready
  );
endinterface

// File: rtl/memory_responder.sv
// Memory responder: mirrored on-chip RAM plus I/O registers at 0xFF00-0xFF02, with optional
// read wait states and a one-entry write buffer that catches writes issued while a read waits.
module memory_responder #(
  parameter int RAM_AW      = 10,
  parameter int WAIT_STATES = 0
) (
  input  logic                clk,
  input  logic                reset_n,
  memory_responder_if.slave   bus,
  input  logic [7:0]          io_in,
  output logic [7:0]          io_out,
  output logic                wr_overrun
);

  localparam logic [15:0] IO_OUT_ADDR = 16'hFF00;
  localparam logic [15:0] IO_IN_ADDR  = 16'hFF01;
  localparam logic [15:0] STATUS_ADDR = 16'hFF02;

  logic [7:0]  ram [0:(1<<RAM_AW)-1];
  logic [7:0]  io_meta;
  logic [7:0]  io_sync;
  logic        pend_valid;
  logic        wr_en;
  logic [15:0] wr_addr;
  logic [7:0]  wr_data;
  logic [7:0]  rd_map;

  // NOTE: sequential state is assigned with <= so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      io_meta <= 8'h00;
      io_sync <= 8'h00;
    end else begin
      io_meta <= io_in;
      io_sync <= io_meta;
    end
  end

  // NOTE: the default assignment first keeps this block combinational (no latch).
  always_comb begin
    rd_map = 8'hFF;
    if (bus.mem_addr < IO_OUT_ADDR) begin
      rd_map = ram[bus.mem_addr[RAM_AW-1:0]];
    end else begin
      case (bus.mem_addr)
        IO_OUT_ADDR: rd_map = io_out;
        IO_IN_ADDR:  rd_map = io_sync;
        STATUS_ADDR: rd_map = {6'b0, pend_valid, wr_overrun};
        default:     rd_map = 8'hFF;
      endcase
    end
  end

  // NOTE: the RAM array is deliberately not reset; contents survive reset_n.
  always_ff @(posedge clk) begin
    if (wr_en && (wr_addr < IO_OUT_ADDR)) begin
      ram[wr_addr[RAM_AW-1:0]] <= wr_data;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      io_out <= 8'h00;
    end else if (wr_en && (wr_addr == IO_OUT_ADDR)) begin
      io_out <= wr_data;
    end
  end

  generate
    if (WAIT_STATES == 0) begin : g_comb
      assign wr_en        = bus.mem_write;
      assign wr_addr      = bus.mem_addr;
      assign wr_data      = bus.mem_wdata;
      assign bus.rd_valid = bus.mem_read;
      assign bus.data_bus = bus.mem_read ? rd_map : 8'h00;
      assign bus.ready    = 1'b1;
      assign pend_valid   = 1'b0;
      assign wr_overrun   = 1'b0;
    end else begin : g_fsm
      localparam logic [1:0] S_IDLE = 2'd0;
      localparam logic [1:0] S_WAIT = 2'd1;
      localparam logic [1:0] S_HOLD = 2'd2;
      localparam logic [2:0] CNT_LOAD = 3'(WAIT_STATES - 1);

      logic [1:0]  state;
      logic [2:0]  cnt;
      logic [7:0]  rd_data;
      logic [15:0] rd_addr;
      logic [15:0] pend_addr;
      logic [7:0]  pend_data;
      logic        pend_q;
      logic        overrun_q;
      logic        wait_done;

      assign wait_done = (state == S_WAIT) && (cnt == 3'd0);

      // The buffered write owns the port on the last wait edge; a fresh write there is
      // only taken directly when nothing is buffered.
      always_comb begin
        wr_en   = 1'b0;
        wr_addr = bus.mem_addr;
        wr_data = bus.mem_wdata;
        if (wait_done && pend_q) begin
          wr_en   = 1'b1;
          wr_addr = pend_addr;
          wr_data = pend_data;
        end else if ((state != S_WAIT) || wait_done) begin
          wr_en = bus.mem_write;
        end
      end

      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          state     <= S_IDLE;
          cnt       <= 3'd0;
          rd_data   <= 8'h00;
          rd_addr   <= 16'h0000;
          pend_addr <= 16'h0000;
          pend_data <= 8'h00;
          pend_q    <= 1'b0;
          overrun_q <= 1'b0;
        end else begin
          case (state)
            S_IDLE: begin
              if (bus.mem_read) begin
                rd_data <= rd_map;
                rd_addr <= bus.mem_addr;
                cnt     <= CNT_LOAD;
                state   <= S_WAIT;
              end
            end
            S_WAIT: begin
              if (cnt == 3'd0) begin
                state  <= S_HOLD;
                pend_q <= 1'b0;
              end else begin
                cnt <= cnt - 3'd1;
              end
              if (bus.mem_write) begin
                if (pend_q) begin
                  overrun_q <= 1'b1;
                end else if (cnt != 3'd0) begin
                  pend_q    <= 1'b1;
                  pend_addr <= bus.mem_addr;
                  pend_data <= bus.mem_wdata;
                end
              end
            end
            S_HOLD: begin
              if (!bus.mem_read || (bus.mem_addr != rd_addr)) begin
                state <= S_IDLE;
              end
            end
            default: state <= S_IDLE;
          endcase
        end
      end

      assign pend_valid   = pend_q;
      assign wr_overrun   = overrun_q;
      assign bus.rd_valid = (state == S_HOLD);
      assign bus.ready    = (state != S_WAIT);
      assign bus.data_bus = (state == S_HOLD) ? rd_data : 8'h00;
    end
  endgenerate

endmodule
